// File: rtl/ballot_session_ctrl_if.sv
// Signal bundle between the ballot session controller and the voting unit.
// Inputs are levels sampled on Clk2; tally_inc, mark_voted and timeout_pulse are one-cycle strobes.
`timescale 1ns/1ps
interface ballot_session_ctrl_if;
    logic       mode;
    logic       enter;
    logic [5:0] uid;
    logic       voter_ok;
    logic       already_voted;
    logic [3:0] cand_req;
    logic [3:0] tally_inc;
    logic       mark_voted;
    logic [5:0] mark_uid;
    logic [7:0] vvpat_code;
    logic       busy;
    logic       armed_led;
    logic       reject_led;
    logic       timeout_pulse;
    logic [2:0] state;
    logic [7:0] sessions_done;

    modport slave (
        input  mode, enter, uid, voter_ok, already_voted, cand_req,
        output tally_inc, mark_voted, mark_uid, vvpat_code, busy,
               armed_led, reject_led, timeout_pulse, state, sessions_done
    );

    modport master (
        output mode, enter, uid, voter_ok, already_voted, cand_req,
        input  tally_inc, mark_voted, mark_uid, vvpat_code, busy,
               armed_led, reject_led, timeout_pulse, state, sessions_done
    );
endinterface

// File: rtl/ballot_session_ctrl.sv
// Voting-session sequencer: verifies a voter, accepts one candidate choice,
// strobes the tally and voted-flag, then shows the VVPAT code for a fixed hold.
`timescale 1ns/1ps
module ballot_session_ctrl #(
    parameter logic [3:0] ARM_TIMEOUT = 4'd15,
    parameter logic [3:0] VVPAT_HOLD  = 4'd7,
    parameter logic [3:0] REJECT_HOLD = 4'd3
) (
    input  logic                  Clk2,
    input  logic                  reset,
    ballot_session_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ARMED  = 3'd2,
        COMMIT = 3'd3,
        VVPAT  = 3'd4,
        REJECT = 3'd5
    } state_t;

    state_t     state_r;
    logic [3:0] timer;
    logic [5:0] uid_q;
    logic [3:0] cand_q;
    logic       enter_q;
    logic [3:0] tally_inc_r;
    logic       mark_voted_r;
    logic [7:0] vvpat_code_r;
    logic       timeout_pulse_r;
    logic [7:0] sessions_done_r;
    logic       enter_rise;

    assign enter_rise = bus.enter & ~enter_q;

    function automatic logic [7:0] vvpat_of(input logic [3:0] c);
        case (c)
            4'b0001: vvpat_of = 8'h01;
            4'b0010: vvpat_of = 8'h02;
            4'b0100: vvpat_of = 8'h03;
            4'b1000: vvpat_of = 8'h04;
            default: vvpat_of = 8'h00;
        endcase
    endfunction

    always_ff @(posedge Clk2 or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            timer           <= 4'd0;
            uid_q           <= 6'd0;
            cand_q          <= 4'd0;
            enter_q         <= 1'b0;
            tally_inc_r     <= 4'd0;
            mark_voted_r    <= 1'b0;
            vvpat_code_r    <= 8'h00;
            timeout_pulse_r <= 1'b0;
            sessions_done_r <= 8'd0;
        end else begin
            enter_q         <= bus.enter;
            tally_inc_r     <= 4'd0;
            mark_voted_r    <= 1'b0;
            timeout_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.mode && enter_rise) begin
                        uid_q   <= bus.uid;
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (!bus.mode) begin
                        state_r <= IDLE;
                    end else if (bus.voter_ok && !bus.already_voted) begin
                        state_r <= ARMED;
                        timer   <= ARM_TIMEOUT;
                    end else begin
                        state_r <= REJECT;
                        timer   <= REJECT_HOLD;
                    end
                end
                ARMED: begin
                    // Mode drop wins over everything; a valid choice wins over the timeout.
                    if (!bus.mode) begin
                        state_r <= IDLE;
                    end else if ($onehot(bus.cand_req)) begin
                        cand_q       <= bus.cand_req;
                        tally_inc_r  <= bus.cand_req;
                        mark_voted_r <= 1'b1;
                        state_r      <= COMMIT;
                    end else if (timer == 4'd0) begin
                        timeout_pulse_r <= 1'b1;
                        state_r         <= IDLE;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                COMMIT: begin
                    if (sessions_done_r != 8'hFF) begin
                        sessions_done_r <= sessions_done_r + 8'd1;
                    end
                    vvpat_code_r <= vvpat_of(cand_q);
                    timer        <= VVPAT_HOLD;
                    state_r      <= VVPAT;
                end
                VVPAT: begin
                    if (timer == 4'd0) begin
                        vvpat_code_r <= 8'h00;
                        state_r      <= IDLE;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                REJECT: begin
                    if (!bus.mode || timer == 4'd0) begin
                        state_r <= IDLE;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                default: begin
                    vvpat_code_r <= 8'h00;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.tally_inc     = tally_inc_r;
    assign bus.mark_voted    = mark_voted_r;
    assign bus.mark_uid      = uid_q;
    assign bus.vvpat_code    = vvpat_code_r;
    assign bus.timeout_pulse = timeout_pulse_r;
    assign bus.sessions_done = sessions_done_r;
    assign bus.state         = state_r;
    assign bus.busy          = (state_r != IDLE);
    assign bus.armed_led     = (state_r == ARMED);
    assign bus.reject_led    = (state_r == REJECT);
endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Bench for ballot_session_ctrl: per-session outcome model (durations, strobes,
// codes, vote count) compared against per-cycle observations of the DUT.
`timescale 1ns/1ps
module tb_ballot_session_ctrl;
    localparam logic [3:0] ARM_TIMEOUT = 4'd15;
    localparam logic [3:0] VVPAT_HOLD  = 4'd7;
    localparam logic [3:0] REJECT_HOLD = 4'd3;
    localparam int ARM_CYC = int'(ARM_TIMEOUT) + 1;
    localparam int VV_CYC  = int'(VVPAT_HOLD) + 1;
    localparam int RJ_CYC  = int'(REJECT_HOLD) + 1;
    localparam int WIN     = 32;

    // Session kinds
    localparam int K_VALID = 0, K_BADID = 1, K_VOTED = 2, K_TMO = 3,
                   K_ADROP = 4, K_VDROP = 5, K_CDROP = 6;

    logic Clk2 = 1'b0;
    logic reset;
    always #5 Clk2 = ~Clk2;

    ballot_session_ctrl_if bus();

    ballot_session_ctrl #(
        .ARM_TIMEOUT(ARM_TIMEOUT),
        .VVPAT_HOLD (VVPAT_HOLD),
        .REJECT_HOLD(REJECT_HOLD)
    ) dut (
        .Clk2 (Clk2),
        .reset(reset),
        .bus  (bus.slave)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_sd = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rand_invalid();
        logic [3:0] r;
        do r = 4'($urandom_range(0, 15)); while ($countones(r) == 1);
        return r;
    endfunction

    function automatic int code_of(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c[i]) return i + 1;
        return 0;
    endfunction

    // One complete session; d = number of ARMED cycles before the choice (or mode drop).
    task automatic run_session(input int kind, input logic [5:0] u, input int d,
                               input logic [3:0] cand, input int inv);
        int  armed_n = 0, st_armed_n = 0, rej_n = 0, vv_n = 0, st_vv_n = 0;
        int  commit_n = 0, busy_n = 0, to_n = 0, mark_n = 0, vv_last = 0;
        bit  commits;
        int  e_armed, e_rej, e_busy, e_to;
        commits = (kind == K_VALID || kind == K_VDROP);
        if (commits) exp_q.push_back(cand);
        for (int c = 0; c < WIN; c++) begin
            if (c == 0) begin
                bus.mode          = 1'b1;
                bus.uid           = u;
                bus.voter_ok      = (kind != K_BADID);
                bus.already_voted = (kind == K_VOTED) ? 1'b1 :
                                    (kind == K_BADID) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.enter         = 1'b1;
                bus.cand_req      = 4'd0;
            end else begin
                if (c == 1 || c == 5) bus.enter = 1'b0;
                if (c == 4) bus.enter = 1'b1;
                if (kind == K_CDROP && c == 1) bus.mode = 1'b0;
                if (c >= 2) begin
                    bus.uid           = 6'($urandom_range(0, 63));
                    bus.voter_ok      = 1'($urandom_range(0, 1));
                    bus.already_voted = 1'($urandom_range(0, 1));
                    if (kind == K_ADROP && c == 2 + d) bus.mode = 1'b0;
                    if (kind == K_VDROP && c == 4 + d) bus.mode = 1'b0;
                    if (kind == K_TMO || ((commits || kind == K_ADROP) && c < 2 + d))
                        bus.cand_req = (inv < 0) ? rand_invalid() : 4'(inv);
                    else if (commits && c == 2 + d)
                        bus.cand_req = cand;
                    else
                        bus.cand_req = 4'($urandom_range(0, 15));
                end
            end
            @(posedge Clk2);
            @(negedge Clk2);
            if (bus.armed_led) armed_n++;
            if (bus.state == 3'd2) st_armed_n++;
            if (bus.reject_led) rej_n++;
            if (bus.state == 3'd3) commit_n++;
            if (bus.state == 3'd4) st_vv_n++;
            if (bus.busy) busy_n++;
            if (bus.timeout_pulse) to_n++;
            if (bus.vvpat_code != 8'h00) begin
                vv_n++;
                vv_last = int'(bus.vvpat_code);
            end
            if (bus.mark_voted) begin
                mark_n++;
                check("mark_uid_at_strobe", 32'(bus.mark_uid), 32'(u));
            end
            if (bus.tally_inc != 4'd0) begin
                if (exp_q.size() == 0) check("tally_unexpected", 32'(bus.tally_inc), 32'd0);
                else check("tally_inc", 32'(bus.tally_inc), 32'(exp_q.pop_front()));
            end
        end
        e_armed = 0; e_rej = 0; e_to = 0; e_busy = 1;
        case (kind)
            K_VALID, K_VDROP: begin e_armed = d + 1; e_busy = 1 + (d + 1) + 1 + VV_CYC; end
            K_BADID, K_VOTED: begin e_rej = RJ_CYC; e_busy = 1 + RJ_CYC; end
            K_TMO:            begin e_armed = ARM_CYC; e_to = 1; e_busy = 1 + ARM_CYC; end
            K_ADROP:          begin e_armed = d + 1; e_busy = 1 + d + 1; end
            default:          e_busy = 1;
        endcase
        if (commits && exp_sd < 255) exp_sd++;
        check("armed_led_cycles", 32'(armed_n), 32'(e_armed));
        check("state_armed_cycles", 32'(st_armed_n), 32'(e_armed));
        check("reject_led_cycles", 32'(rej_n), 32'(e_rej));
        check("commit_cycles", 32'(commit_n), commits ? 32'd1 : 32'd0);
        check("vvpat_cycles", 32'(vv_n), commits ? 32'(VV_CYC) : 32'd0);
        check("state_vvpat_cycles", 32'(st_vv_n), commits ? 32'(VV_CYC) : 32'd0);
        check("vvpat_code", 32'(vv_last), commits ? 32'(code_of(cand)) : 32'd0);
        check("busy_cycles", 32'(busy_n), 32'(e_busy));
        check("timeout_pulses", 32'(to_n), 32'(e_to));
        check("mark_voted_strobes", 32'(mark_n), commits ? 32'd1 : 32'd0);
        check("mark_uid_latched", 32'(bus.mark_uid), 32'(u));
        check("sessions_done", 32'(bus.sessions_done), 32'(exp_sd));
        check("final_state_idle", 32'(bus.state), 32'd0);
        check("tally_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Reset asserted mid-commit or mid-VVPAT must clear everything at once.
    task automatic reset_mid(input bit in_commit);
        bus.mode = 1'b1; bus.uid = 6'd21; bus.voter_ok = 1'b1; bus.already_voted = 1'b0;
        bus.enter = 1'b1; bus.cand_req = 4'd0;
        @(posedge Clk2); #1 bus.enter = 1'b0;
        @(posedge Clk2); #1 bus.cand_req = 4'b0100;
        @(posedge Clk2);
        if (in_commit) begin
            #1 check("pre_reset_tally", 32'(bus.tally_inc), 32'b0100);
            #2 reset = 1'b1;
            #1 check("rst_commit_tally", 32'(bus.tally_inc), 32'd0);
            check("rst_commit_mark", 32'(bus.mark_voted), 32'd0);
            check("rst_commit_state", 32'(bus.state), 32'd0);
        end else begin
            repeat (3) @(posedge Clk2);
            #1 check("pre_reset_vvpat", 32'(bus.vvpat_code), 32'h03);
            #2 reset = 1'b1;
            #1 check("rst_vvpat_code", 32'(bus.vvpat_code), 32'h00);
            check("rst_vvpat_state", 32'(bus.state), 32'd0);
        end
        bus.cand_req = 4'd0;
        @(negedge Clk2) reset = 1'b0;
        exp_sd = 0;
        exp_q.delete();
        repeat (3) @(negedge Clk2);
        check("post_reset_sessions", 32'(bus.sessions_done), 32'd0);
        check("post_reset_state", 32'(bus.state), 32'd0);
        check("post_reset_tally", 32'(bus.tally_inc), 32'd0);
    endtask

    initial begin
        int kind, d;
        reset = 1'b1;
        bus.mode = 1'b0; bus.enter = 1'b0; bus.uid = 6'd0;
        bus.voter_ok = 1'b0; bus.already_voted = 1'b0; bus.cand_req = 4'd0;
        repeat (2) @(negedge Clk2);
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_tally", 32'(bus.tally_inc), 32'd0);
        check("reset_mark", 32'(bus.mark_voted), 32'd0);
        check("reset_vvpat", 32'(bus.vvpat_code), 32'd0);
        check("reset_sessions", 32'(bus.sessions_done), 32'd0);
        check("reset_status", {28'd0, bus.busy, bus.armed_led, bus.reject_led, bus.timeout_pulse}, 32'd0);
        check("reset_mark_uid", 32'(bus.mark_uid), 32'd0);
        reset = 1'b0;
        @(negedge Clk2);

        run_session(K_VALID, 6'd5, 2, 4'b0100, -1);
        run_session(K_VOTED, 6'd5, 0, 4'd0, -1);
        run_session(K_TMO,   6'd9, 0, 4'd0, 0);
        run_session(K_VALID, 6'd12, 1, 4'b0001, 3);
        run_session(K_ADROP, 6'd7, 3, 4'd0, -1);
        run_session(K_VDROP, 6'd8, 2, 4'b1000, -1);
        run_session(K_VALID, 6'd3, int'(ARM_TIMEOUT), 4'b0010, -1);
        run_session(K_CDROP, 6'd4, 0, 4'd0, -1);
        run_session(K_BADID, 6'd40, 0, 4'd0, -1);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 6);
            d = (kind == K_ADROP) ? $urandom_range(0, int'(ARM_TIMEOUT) - 1)
                                  : $urandom_range(0, int'(ARM_TIMEOUT));
            run_session(kind, 6'($urandom_range(0, 63)), d,
                        4'(1 << $urandom_range(0, 3)), -1);
        end

        reset_mid(1'b1);
        reset_mid(1'b0);

        for (int i = 0; i < 256; i++)
            run_session(K_VALID, 6'($urandom_range(0, 63)), $urandom_range(0, 2),
                        4'(1 << $urandom_range(0, 3)), -1);
        run_session(K_VALID, 6'd33, 0, 4'b0001, -1);
        check("sessions_saturated", 32'(bus.sessions_done), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ballot_session_ctrl.md
BALLOT_SESSION_CTRL -- requirements
Module: ballot_session_ctrl

Interface
REQ-001 Parameter ARM_TIMEOUT, default 4'd15, Clk2 ticks a verified voter may take to choose before the session is abandoned.
REQ-002 Parameter VVPAT_HOLD, default 4'd7, Clk2 ticks the VVPAT code is held after a commit.
REQ-003 Parameter REJECT_HOLD, default 4'd3, Clk2 ticks the reject indication is held.
REQ-004 Clk2  in  1  session clock, about 1 s period; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mode  in  1  1 = voting mode, 0 = result mode.
REQ-007 enter  in  1  voter-entry request, level; only a rising edge starts a session.
REQ-008 uid  in  6  voter identification number.
REQ-009 voter_ok  in  1  voter-database lookup result for the current uid.
REQ-010 already_voted  in  1  voted-flag for the current uid.
REQ-011 cand_req  in  4  debounced candidate buttons; bit0 = candidate 1.
REQ-012 tally_inc  out  4  one-hot, one-cycle increment strobe to the tally counters.
REQ-013 mark_voted  out  1  one-cycle strobe that sets the voted-flag of mark_uid.
REQ-014 mark_uid  out  6  latched uid of the current session.
REQ-015 vvpat_code  out  8  8'h01..8'h04 for candidates 1..4; 8'h00 otherwise.
REQ-016 busy, armed_led, reject_led, timeout_pulse  out  1 each  status outputs.
REQ-017 state  out  3  current FSM state encoding.
REQ-018 sessions_done  out  8  count of committed votes.

Function
REQ-019 States and encodings: IDLE = 0, CHECK = 1, ARMED = 2, COMMIT = 3, VVPAT = 4, REJECT = 5; the FSM never enters codes 6 and 7, and any such code returns to IDLE on the next edge.
REQ-020 Edge detection: enter is registered to enter_q, and enter_rise = enter & ~enter_q.
REQ-021 IDLE: when mode = 1 and enter_rise = 1, the block latches uid into uid_q and moves to CHECK; otherwise it stays in IDLE.
REQ-022 CHECK lasts exactly one cycle and decides from voter_ok and already_voted:
  - voter_ok = 1 and already_voted = 0: go to ARMED and load timer = ARM_TIMEOUT.
  - any other combination: go to REJECT and load timer = REJECT_HOLD.
REQ-023 ARMED, valid choice: if cand_req has exactly one bit set, latch that bit into cand_q and go to COMMIT.
REQ-024 ARMED, invalid choice: a cand_req with zero bits or with two or more bits set is ignored, and the timer decrements.
REQ-025 ARMED, timeout: if no valid choice arrives and timer = 0, the block goes to IDLE and pulses timeout_pulse for one cycle.
REQ-026 Choice beats timeout: a valid choice seen in the same cycle as timer = 0 still goes to COMMIT.
REQ-027 COMMIT lasts exactly one cycle and does all of the following:
  - drives tally_inc = cand_q and mark_voted = 1;
  - increments sessions_done, saturating at 8'hFF;
  - goes to VVPAT and loads timer = VVPAT_HOLD.
REQ-028 VVPAT: vvpat_code is driven from cand_q for the whole state; the timer decrements each cycle, and at timer = 0 the block goes to IDLE and vvpat_code returns to 8'h00.
REQ-029 REJECT: reject_led = 1 for the whole state; the timer decrements, and at timer = 0 the block goes to IDLE.
REQ-030 Timer rule: a timed state entered with load value N lasts N+1 cycles; the timer is 4 bits wide and never wraps below 0.
REQ-031 When mode = 0 in CHECK, ARMED or REJECT, the block goes to IDLE on the next edge with no strobes issued; COMMIT and VVPAT always run to completion regardless of mode.
REQ-032 Changes on uid, voter_ok or already_voted after CHECK have no effect, and mark_uid always equals uid_q.
REQ-033 An enter_rise outside IDLE is ignored, so a second session cannot start until the block has returned to IDLE.
REQ-034 Status decode: busy = 1 whenever state is not IDLE; armed_led = 1 only in ARMED.
REQ-035 All outputs are registered or decoded from registered state, with no combinational path from any input to any output.

Reset
REQ-036 While reset = 1, the block holds the following values, forced asynchronously:
  - state = IDLE; timer, uid_q, cand_q and enter_q = 0;
  - tally_inc = 0, mark_voted = 0, vvpat_code = 8'h00, sessions_done = 0;
  - all LEDs and timeout_pulse = 0.
REQ-037 Reset asserted in any state, including COMMIT, suppresses every strobe in that cycle; no partial vote is recorded.

Verification
REQ-038 Valid vote: mode = 1, uid = 6'd5, voter_ok = 1, already_voted = 0, enter rises, then cand_req = 4'b0100 -> one COMMIT cycle with tally_inc = 4'b0100, mark_voted = 1, mark_uid = 6'd5; vvpat_code = 8'h03 for 8 cycles; sessions_done = 1.
REQ-039 Double vote: same uid with already_voted = 1 -> REJECT for 4 cycles with reject_led = 1; no tally_inc or mark_voted strobe.
REQ-040 Timeout: verified voter, cand_req held at 0 -> ARMED for 16 cycles, then timeout_pulse = 1 for one cycle, state = IDLE, sessions_done unchanged.
REQ-041 Multi-press: cand_req = 4'b0011 in ARMED -> no commit; a following cand_req = 4'b0001 -> tally_inc = 4'b0001.
REQ-042 Mode drop: mode goes to 0 while in ARMED -> IDLE next cycle with no strobes; mode goes to 0 during VVPAT -> the full 8-cycle hold completes.
REQ-043 Reset and saturation: reset asserted mid-VVPAT -> vvpat_code = 8'h00 and state = IDLE at once; 256 commits -> sessions_done = 8'hFF.
